// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: op codes, FSM states and byte-enable masks.
package mem_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH  = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW  = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Big-endian lanes: byte offset 0 lives in bits 31:24
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering, store replication and load extension for mem_lsu.
// MEM_ALIGN_EXC_EN: flag misaligned halfword/word accesses instead of silently aligning them.
module mem_align
  import mem_pkg::*;
(
  input  logic [MEM_OP_W-1:0] op_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [31:0]         sdata_i,
  input  logic [31:0]         rdata_i,
  output logic [3:0]          sel_o,
  output logic [31:0]         wdata_o,
  output logic [31:0]         ldata_o,
  output logic                misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        half_bad;
  logic        word_bad;

  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_v = rdata_i[31:24];
      2'b01:   byte_v = rdata_i[23:16];
      2'b10:   byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    // addr[0] is ignored for halfwords, which is the same as forcing it to 0
    half_v   = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    half_bad = addr_lo_i[0];
    word_bad = |addr_lo_i;
  end

  always_comb begin
    sel_o      = 4'b0000;
    wdata_o    = '0;
    ldata_o    = '0;
    misalign_o = 1'b0;
    case (op_i)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        sel_o   = SEL_B0 >> addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = (op_i == MEM_OP_LB) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        sel_o      = addr_lo_i[1] ? SEL_H1 : SEL_H0;
        wdata_o    = {2{sdata_i[15:0]}};
        ldata_o    = (op_i == MEM_OP_LH) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
`ifdef MEM_ALIGN_EXC_EN
        misalign_o = half_bad;
`else
        misalign_o = 1'b0;
`endif
      end
      MEM_OP_LW, MEM_OP_SW: begin
        sel_o      = SEL_W;
        wdata_o    = sdata_i;
        ldata_o    = rdata_i;
`ifdef MEM_ALIGN_EXC_EN
        misalign_o = word_bad;
`else
        misalign_o = 1'b0;
`endif
      end
      default: begin
        sel_o = 4'b0000;
      end
    endcase
  end

`ifndef MEM_ALIGN_EXC_EN
  logic unused_bad;
  assign unused_bad = half_bad ^ word_bad;
`endif

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: req/ack bus FSM with pipeline stall and writeback steering.
// MEM_ALIGN_EXC_EN (in mem_align): misaligned accesses raise misalign_o instead of going to the bus.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic                mem_wreg_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [MEM_OP_W-1:0] mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [31:0]         mem_sdata_i,
  output logic [REG_AW-1:0]   mem_wd_o,
  output logic                mem_wreg_o,
  output logic [31:0]         mem_wdata_o,
  output logic                stallreq_o,
  output logic                dbus_req_o,
  output logic                dbus_we_o,
  output logic [ADDR_W-1:0]   dbus_addr_o,
  output logic [3:0]          dbus_sel_o,
  output logic [31:0]         dbus_wdata_o,
  input  logic                dbus_ack_i,
  input  logic [31:0]         dbus_rdata_i,
  output logic                misalign_o
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] ldata;
  logic        misalign;
  logic        is_ld, is_st, is_mem, go, bus_act;

  mem_align u_align (
    .op_i       (mem_op_i),
    .addr_lo_i  (mem_addr_i[1:0]),
    .sdata_i    (mem_sdata_i),
    .rdata_i    (dbus_rdata_i),
    .sel_o      (sel),
    .wdata_o    (wdata),
    .ldata_o    (ldata),
    .misalign_o (misalign)
  );

  assign is_ld   = op_is_load(mem_op_i);
  assign is_st   = op_is_store(mem_op_i);
  assign is_mem  = is_ld | is_st;
  assign go      = is_mem & ~misalign;
  assign bus_act = ((state_q == IDLE) & go) | (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (dbus_ack_i) begin
            rdata_d = ldata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus_ack_i) begin
          rdata_d = ldata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by reset directly so the bus request drops without a clock edge
  always_comb begin
    mem_wd_o     = '0;
    mem_wreg_o   = 1'b0;
    mem_wdata_o  = '0;
    stallreq_o   = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_sel_o   = 4'b0000;
    dbus_wdata_o = '0;
    misalign_o   = 1'b0;
    if (rst) begin
      mem_wd_o    = mem_wd_i;
      mem_wdata_o = ((state_q == DONE) && is_ld) ? rdata_q : mem_wdata_i;
      mem_wreg_o  = (state_q == DONE) ? mem_wreg_i :
                    ((state_q == IDLE) && !is_mem) ? mem_wreg_i : 1'b0;
      misalign_o  = (state_q == IDLE) && is_mem && misalign;
      if (bus_act) begin
        stallreq_o   = 1'b1;
        dbus_req_o   = 1'b1;
        dbus_we_o    = is_st;
        dbus_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
        dbus_sel_o   = sel;
        dbus_wdata_o = is_st ? wdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences and a randomized model check.
// Honours MEM_ALIGN_EXC_EN when computing expectations for misaligned accesses.
module tb_mem_lsu;
  import mem_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wd;
    logic        wreg;
    int          dly;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_bwd;
    logic [31:0] e_res;
    logic        e_mis;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic        stallreq_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_lsu #(.ADDR_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd_i     (mem_wd_i),
    .mem_wreg_i   (mem_wreg_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .mem_sdata_i  (mem_sdata_i),
    .mem_wd_o     (mem_wd_o),
    .mem_wreg_o   (mem_wreg_o),
    .mem_wdata_o  (mem_wdata_o),
    .stallreq_o   (stallreq_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] wd,
                              input logic wreg, input int dly, input logic [3:0] e_sel, input logic e_we,
                              input logic [31:0] e_bwd, input logic [31:0] e_res);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.alu = alu; v.rdata = rdata;
    v.wd = wd; v.wreg = wreg; v.dly = dly; v.e_sel = e_sel; v.e_we = e_we;
    v.e_bwd = e_bwd; v.e_res = e_res; v.e_mis = 1'b0;
    return v;
  endfunction

  // Reference model: lane position and extension derived arithmetically from the byte offset
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] k, hk, b, h;
    logic bad_half, bad_word;
    k = v.addr & 32'd3;
    hk = k & 32'd2;
    b = (v.rdata >> (8 * (3 - k))) & 32'hFF;
    h = (v.rdata >> (8 * (2 - hk))) & 32'hFFFF;
    bad_half = (k % 2) != 0;
    bad_word = k != 0;
    r.e_sel = 4'h0; r.e_we = 1'b0; r.e_bwd = 32'h0; r.e_res = v.alu; r.e_mis = 1'b0;
    case (v.op)
      MEM_OP_LB:  begin r.e_sel = 4'(1 << (3 - k)); r.e_res = (b >= 128) ? b - 32'd256 : b; end
      MEM_OP_LBU: begin r.e_sel = 4'(1 << (3 - k)); r.e_res = b; end
      MEM_OP_LH:  begin r.e_sel = 4'(3 << (2 - hk)); r.e_res = (h >= 32768) ? h - 32'd65536 : h; r.e_mis = bad_half; end
      MEM_OP_LHU: begin r.e_sel = 4'(3 << (2 - hk)); r.e_res = h; r.e_mis = bad_half; end
      MEM_OP_LW:  begin r.e_sel = 4'hF; r.e_res = v.rdata; r.e_mis = bad_word; end
      MEM_OP_SB:  begin r.e_sel = 4'(1 << (3 - k)); r.e_we = 1'b1; r.e_bwd = (v.sdata & 32'hFF) * 32'h01010101; end
      MEM_OP_SH:  begin r.e_sel = 4'(3 << (2 - hk)); r.e_we = 1'b1; r.e_bwd = (v.sdata & 32'hFFFF) * 32'h00010001; r.e_mis = bad_half; end
      MEM_OP_SW:  begin r.e_sel = 4'hF; r.e_we = 1'b1; r.e_bwd = v.sdata; r.e_mis = bad_word; end
      default:    r.e_res = v.alu;
    endcase
`ifndef MEM_ALIGN_EXC_EN
    r.e_mis = 1'b0;
`endif
    return r;
  endfunction

  // Drives one ex_mem record and checks every cycle until it leaves the stage
  task automatic apply_stimulus(input vec_t v, input string tag);
    bit mem;
    int stalls;
    mem = (v.op >= 4'd1) && (v.op <= 4'd8);
    mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata; mem_wdata_i = v.alu;
    mem_wd_i = v.wd; mem_wreg_i = v.wreg; dbus_rdata_i = v.rdata; dbus_ack_i = 1'b0;
    if (!mem || v.e_mis) begin
      @(negedge clk);
      check_output(tag, "wd", 32'(mem_wd_o), 32'(v.wd));
      check_output(tag, "wreg", 32'(mem_wreg_o), v.e_mis ? 32'd0 : 32'(v.wreg));
      check_output(tag, "wdata", mem_wdata_o, v.alu);
      check_output(tag, "stall", 32'(stallreq_o), 32'd0);
      check_output(tag, "req", 32'(dbus_req_o), 32'd0);
      check_output(tag, "misalign", 32'(misalign_o), 32'(v.e_mis));
      @(posedge clk); #1;
      return;
    end
    stalls = 0;
    for (int i = 0; i <= v.dly; i++) begin
      dbus_ack_i = (i == v.dly);
      @(negedge clk);
      if (stallreq_o) stalls++;
      check_output(tag, "req", 32'(dbus_req_o), 32'd1);
      check_output(tag, "we", 32'(dbus_we_o), 32'(v.e_we));
      check_output(tag, "addr", dbus_addr_o, {v.addr[31:2], 2'b00});
      check_output(tag, "sel", 32'(dbus_sel_o), 32'(v.e_sel));
      if (v.e_we) check_output(tag, "bus_wdata", dbus_wdata_o, v.e_bwd);
      check_output(tag, "wreg_stalled", 32'(mem_wreg_o), 32'd0);
      check_output(tag, "misalign", 32'(misalign_o), 32'd0);
      @(posedge clk); #1;
    end
    dbus_ack_i = 1'b0;
    dbus_rdata_i = $urandom;
    @(negedge clk);
    check_output(tag, "stall_cycles", 32'(stalls), 32'(v.dly + 1));
    check_output(tag, "done_stall", 32'(stallreq_o), 32'd0);
    check_output(tag, "done_req", 32'(dbus_req_o), 32'd0);
    check_output(tag, "done_wd", 32'(mem_wd_o), 32'(v.wd));
    check_output(tag, "done_wreg", 32'(mem_wreg_o), 32'(v.wreg));
    check_output(tag, "done_wdata", mem_wdata_o, v.e_res);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   r;

  initial begin
    rst = 1'b0;
    mem_op_i = MEM_OP_NOP; mem_wd_i = 5'd3; mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234;
    mem_addr_i = 32'h0; mem_sdata_i = 32'h0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;

    #3;
    check_output("reset", "wd", 32'(mem_wd_o), 32'd0);
    check_output("reset", "wreg", 32'(mem_wreg_o), 32'd0);
    check_output("reset", "wdata", mem_wdata_o, 32'd0);
    check_output("reset", "stall", 32'(stallreq_o), 32'd0);
    mem_op_i = MEM_OP_LW; mem_addr_i = 32'h40;
    #1;
    check_output("reset", "req", 32'(dbus_req_o), 32'd0);
    check_output("reset", "misalign", 32'(misalign_o), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    tbl.push_back(mk(MEM_OP_NOP, 32'h0,   32'h0,        32'h1234, 32'h0,        5'd3, 1'b1, 0, 4'h0,    1'b0, 32'h0,        32'h1234));
    tbl.push_back(mk(MEM_OP_LB,  32'h101, 32'h0,        32'h101,  32'h11F03344, 5'd8, 1'b1, 0, 4'b0100, 1'b0, 32'h0,        32'hFFFFFFF0));
    tbl.push_back(mk(MEM_OP_LBU, 32'h101, 32'h0,        32'h101,  32'h11F03344, 5'd8, 1'b1, 0, 4'b0100, 1'b0, 32'h0,        32'h000000F0));
    tbl.push_back(mk(MEM_OP_SH,  32'h202, 32'h0000ABCD, 32'h202,  32'h0,        5'd0, 1'b0, 3, 4'b0011, 1'b1, 32'hABCDABCD, 32'h202));
    tbl.push_back(mk(MEM_OP_LW,  32'h300, 32'h0,        32'h300,  32'hDEADBEEF, 5'd9, 1'b1, 1, 4'hF,    1'b0, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(MEM_OP_LH,  32'h102, 32'h0,        32'h102,  32'h11F08344, 5'd4, 1'b1, 2, 4'b0011, 1'b0, 32'h0,        32'hFFFF8344));
    tbl.push_back(mk(MEM_OP_LHU, 32'h100, 32'h0,        32'h100,  32'h80011234, 5'd5, 1'b1, 0, 4'b1100, 1'b0, 32'h0,        32'h00008001));
    tbl.push_back(mk(MEM_OP_SB,  32'h003, 32'h1234565A, 32'h3,    32'h0,        5'd0, 1'b0, 1, 4'b0001, 1'b1, 32'h5A5A5A5A, 32'h3));
    tbl.push_back(mk(MEM_OP_SW,  32'h010, 32'hCAFEF00D, 32'h10,   32'h0,        5'd0, 1'b0, 2, 4'hF,    1'b1, 32'hCAFEF00D, 32'h10));
    tbl.push_back(mk(MEM_OP_LB,  32'h104, 32'h0,        32'h104,  32'h80000000, 5'd6, 1'b1, 0, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80));
    tbl.push_back(mk(4'hF,       32'h777, 32'h0,        32'h55AA, 32'h0,        5'd7, 1'b1, 0, 4'h0,    1'b0, 32'h0,        32'h55AA));
    foreach (tbl[i]) apply_stimulus(tbl[i], $sformatf("vec%0d", i));

    rv = model(mk(MEM_OP_LW, 32'h302, 32'h0, 32'h302, 32'h01020304, 5'd2, 1'b1, 0, 4'h0, 1'b0, 32'h0, 32'h0));
    apply_stimulus(rv, "lw_misaligned");
    apply_stimulus(mk(MEM_OP_NOP, 32'h0, 32'h0, 32'hA5A5, 32'h0, 5'd1, 1'b1, 0, 4'h0, 1'b0, 32'h0, 32'hA5A5), "after_mis");

    mem_op_i = MEM_OP_LW; mem_addr_i = 32'h400; mem_wd_i = 5'd10; mem_wreg_i = 1'b1;
    mem_wdata_i = 32'h400; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h12345678;
    @(posedge clk); #2;
    check_output("rst_wait", "req_before", 32'(dbus_req_o), 32'd1);
    rst = 1'b0;
    #1;
    check_output("rst_wait", "req_async", 32'(dbus_req_o), 32'd0);
    check_output("rst_wait", "stall_async", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_op_i = MEM_OP_NOP; mem_wreg_i = 1'b0; mem_wdata_i = 32'hBEEF;
    @(posedge clk); #1;
    dbus_ack_i = 1'b1;
    @(negedge clk);
    check_output("late_ack", "stall", 32'(stallreq_o), 32'd0);
    check_output("late_ack", "req", 32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    @(negedge clk);
    check_output("late_ack", "wreg", 32'(mem_wreg_o), 32'd0);
    check_output("late_ack", "wdata", mem_wdata_o, 32'hBEEF);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      rv.op    = (r == 9) ? 4'hC : 4'(r);
      rv.addr  = $urandom;
      rv.sdata = $urandom;
      rv.alu   = $urandom;
      rv.rdata = $urandom;
      rv.wd    = 5'($urandom);
      rv.wreg  = 1'($urandom);
      rv.dly   = $urandom_range(0, 3);
      rv = model(rv);
      apply_stimulus(rv, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
